// File: rtl/hazard_stall_controller.sv
//------------------------------------------------------------------------------
// hazard_stall_controller
//   Stall/flush sequencer for the 5-stage pipeline. It drives the PC and
//   IF/ID load enables and the IF/ID and ID/EX flushes. It handles load-use
//   hazards and taken branches, and freezes the front end while the
//   iterative mul/div unit occupies EX.
//   Optional macro HAZARD_STATS_EN adds the StallCycles and FlushEvents
//   32-bit event counters.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_controller #(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRt,
   input  logic       ID_IsMulDiv,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_Rd,
   input  logic       Branch_Taken,
   output logic       PCWrite,
   output logic       IFID_Write,
   output logic       IFID_Flush,
   output logic       IDEX_Flush,
   output logic       Busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushEvents
`endif
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_BUSY = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load_use;
   logic             pc_write_c;
   logic             ifid_write_c;
   logic             ifid_flush_c;
   logic             idex_flush_c;

   // A load in EX whose destination feeds the ID instruction; r0 is never a hazard
   assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                     ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));

   // Priority decode: branch flush, mul/div freeze, load-use bubble, mul/div issue
   always_comb begin
      pc_write_c   = 1'b1;
      ifid_write_c = 1'b1;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      state_nxt    = state;
      cnt_nxt      = cnt;
      if (Branch_Taken) begin
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
         state_nxt    = RUN;
         cnt_nxt      = '0;
      end else if (state == MD_BUSY) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         idex_flush_c = 1'b1;
         if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end else if (load_use) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         idex_flush_c = 1'b1;
      end else if (ID_IsMulDiv) begin
         state_nxt = MD_BUSY;
         cnt_nxt   = CNT_W'(MULDIV_CYCLES - 1);
      end
   end

   // While reset is held the pipeline free-runs with no flushes
   assign PCWrite    = Reset | pc_write_c;
   assign IFID_Write = Reset | ifid_write_c;
   assign IFID_Flush = ~Reset & ifid_flush_c;
   assign IDEX_Flush = ~Reset & idex_flush_c;
   assign Busy       = (state == MD_BUSY);

   // State and busy down-counter
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_STATS_EN
   // Event counters: stalled-PC cycles and branch flush cycles, wrapping
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         StallCycles <= '0;
         FlushEvents <= '0;
      end else begin
         if (!PCWrite)     StallCycles <= StallCycles + 32'd1;
         if (Branch_Taken) FlushEvents <= FlushEvents + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
//------------------------------------------------------------------------------
// tb_hazard_stall_controller
//   Directed plus randomized bench for hazard_stall_controller. A reference
//   model tracks the remaining freeze cycles and the event totals as plain
//   integers.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_controller;

   localparam int MULDIV_CYCLES = 4;
   localparam int CNT_W         = 4;

   logic       Clk;
   logic       Reset;
   logic [4:0] ID_Rs;
   logic [4:0] ID_Rt;
   logic       ID_UsesRt;
   logic       ID_IsMulDiv;
   logic       EX_MemRead;
   logic [4:0] EX_Rd;
   logic       Branch_Taken;
   logic       PCWrite;
   logic       IFID_Write;
   logic       IFID_Flush;
   logic       IDEX_Flush;
   logic       Busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCycles;
   logic [31:0] FlushEvents;
`endif

   int          checks   = 0;
   int          failures = 0;

   // Reference model state
   int          freeze_left = 0;
   logic [31:0] m_stalls    = 0;
   logic [31:0] m_flushes   = 0;

   hazard_stall_controller #(
      .MULDIV_CYCLES(MULDIV_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .ID_Rs       (ID_Rs),
      .ID_Rt       (ID_Rt),
      .ID_UsesRt   (ID_UsesRt),
      .ID_IsMulDiv (ID_IsMulDiv),
      .EX_MemRead  (EX_MemRead),
      .EX_Rd       (EX_Rd),
      .Branch_Taken(Branch_Taken),
      .PCWrite     (PCWrite),
      .IFID_Write  (IFID_Write),
      .IFID_Flush  (IFID_Flush),
      .IDEX_Flush  (IDEX_Flush),
      .Busy        (Busy)
`ifdef HAZARD_STATS_EN
      ,
      .StallCycles (StallCycles),
      .FlushEvents (FlushEvents)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs (called just after a rising edge), check the
   // combinational response mid-cycle, then advance the model over the edge.
   task automatic step(input string tag, input logic bt, input logic md, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut);
      logic lu;
      logic e_pcw, e_ifw, e_iff, e_idf;
      Branch_Taken = bt;
      ID_IsMulDiv  = md;
      EX_MemRead   = mr;
      EX_Rd        = rd;
      ID_Rs        = rs;
      ID_Rt        = rt;
      ID_UsesRt    = ut;
      lu = mr && (rd != 0) && ((rd == rs) || (ut && (rd == rt)));
      e_pcw = 1'b1; e_ifw = 1'b1; e_iff = 1'b0; e_idf = 1'b0;
      if (bt) begin
         e_iff = 1'b1; e_idf = 1'b1;
      end else if (freeze_left > 0 || lu) begin
         e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
      end
      @(negedge Clk);
      chk({tag, ".PCWrite"},    32'(PCWrite),    32'(e_pcw));
      chk({tag, ".IFID_Write"}, 32'(IFID_Write), 32'(e_ifw));
      chk({tag, ".IFID_Flush"}, 32'(IFID_Flush), 32'(e_iff));
      chk({tag, ".IDEX_Flush"}, 32'(IDEX_Flush), 32'(e_idf));
      chk({tag, ".Busy"},       32'(Busy),       32'(freeze_left > 0));
`ifdef HAZARD_STATS_EN
      chk({tag, ".StallCycles"}, StallCycles, m_stalls);
      chk({tag, ".FlushEvents"}, FlushEvents, m_flushes);
`endif
      @(posedge Clk);
      #1;
      if (!e_pcw) m_stalls  = m_stalls + 32'd1;
      if (bt)     m_flushes = m_flushes + 32'd1;
      if (bt)                   freeze_left = 0;
      else if (freeze_left > 0) freeze_left = freeze_left - 1;
      else if (!lu && md)       freeze_left = MULDIV_CYCLES - 1;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      Reset = 1'b1;
      Branch_Taken = 1'b0; ID_IsMulDiv = 1'b0; EX_MemRead = 1'b0;
      EX_Rd = '0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;

      // Reset state
      @(posedge Clk);
      #1;
      chk("rst.PCWrite",    32'(PCWrite),    32'd1);
      chk("rst.IFID_Write", 32'(IFID_Write), 32'd1);
      chk("rst.IFID_Flush", 32'(IFID_Flush), 32'd0);
      chk("rst.IDEX_Flush", 32'(IDEX_Flush), 32'd0);
      chk("rst.Busy",       32'(Busy),       32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      idle("idle");
      // Load-use on rs: exactly one bubble
      step("lu_rs",   1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
      step("lu_done", 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0);
      // No false stalls
      step("rd_zero", 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      step("rt_unused", 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
      step("lu_rt",   1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1);
      // Mul/div freeze: issue, three frozen cycles, then back to RUN
      step("md_issue", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      step("md_busy1", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      step("md_busy2", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      step("md_busy3", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("md_done");
      // Load-use beats mul/div issue, which then issues next cycle
      step("lu_md",    1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
      step("md_after", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("md_b1");
      idle("md_b2");
      idle("md_b3");
      idle("md_run");
      // Branch during the second frozen cycle aborts the freeze
      step("br_issue", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("br_busy1");
      step("br_abort", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("br_after");

      // Reset asserted mid-freeze, with a branch present while held
      step("rm_issue", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle("rm_busy1");
      Reset = 1'b1;
      Branch_Taken = 1'b1;
      #1;
      chk("rm.Busy",       32'(Busy),       32'd0);
      chk("rm.PCWrite",    32'(PCWrite),    32'd1);
      chk("rm.IFID_Write", 32'(IFID_Write), 32'd1);
      chk("rm.IFID_Flush", 32'(IFID_Flush), 32'd0);
      chk("rm.IDEX_Flush", 32'(IDEX_Flush), 32'd0);
`ifdef HAZARD_STATS_EN
      chk("rm.StallCycles", StallCycles, 32'd0);
      chk("rm.FlushEvents", FlushEvents, 32'd0);
`endif
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      freeze_left = 0;
      m_stalls    = 0;
      m_flushes   = 0;
      step("st_lu", 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      step("st_br", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef HAZARD_STATS_EN
      chk("st.StallCycles", StallCycles, 32'd1);
      chk("st.FlushEvents", FlushEvents, 32'd1);
`endif

      // Randomized traffic, small register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step("rnd",
              1'($urandom_range(0, 99) < 12),
              1'($urandom_range(0, 99) < 20),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
